// File: rtl/csr_timer_pkg.sv
// Shared CSR layout for the timer block: TCFG fields, TICLR clear bit, rdcnt select bits.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package csr_timer_pkg;

    // TCFG layout: [0] EN, [1] PERIODIC, [31:2] INITVAL
    typedef struct packed {
        logic [29:0] initval;
        logic        periodic;
        logic        en;
    } tcfg_t;

    localparam int TICLR_CLR_BIT = 0;

    // rdcnt_op one-hot order: {rdcntid, rdcntvh, rdcntvl}
    localparam int RDCNT_VL_BIT = 0;
    localparam int RDCNT_VH_BIT = 1;
    localparam int RDCNT_ID_BIT = 2;

    // Countdown start value: INITVAL scaled by 4
    function automatic logic [31:0] tcfg_reload(input tcfg_t cfg);
        return {cfg.initval, 2'b00};
    endfunction

endpackage

// File: rtl/csr_timer_if.sv
// CSR-side bundle of the timer: write strobes/data, stall, read select and readback values.
// Latency: none (wires only).
// Backpressure: stall from the bus side drops writes; there is no ready back.
interface csr_timer_if;
    logic        stall;
    logic        tcfg_we;
    logic [31:0] tcfg_wdata;
    logic        ticlr_we;
    logic [31:0] ticlr_wdata;
    logic        tid_we;
    logic [31:0] tid_wdata;
    logic [2:0]  rdcnt_op;
    logic [31:0] rdcnt_data;
    logic [31:0] tcfg_out;
    logic [31:0] tval_out;
    logic [31:0] tid_out;
    logic        timer_int;

    modport master (
        output stall, tcfg_we, tcfg_wdata, ticlr_we, ticlr_wdata,
               tid_we, tid_wdata, rdcnt_op,
        input  rdcnt_data, tcfg_out, tval_out, tid_out, timer_int
    );

    modport slave (
        input  stall, tcfg_we, tcfg_wdata, ticlr_we, ticlr_wdata,
               tid_we, tid_wdata, rdcnt_op,
        output rdcnt_data, tcfg_out, tval_out, tid_out, timer_int
    );
endinterface

// File: rtl/csr_timer_stable_counter.sv
// stable_counter: free-running CNT_W-bit counter, wraps from all-ones to zero.
// Latency: count reflects each rising edge; reads are the registered value.
// Backpressure: none; counts every cycle regardless of pipeline stall.
module stable_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic [CNT_W-1:0] count
);

    // Increment every cycle; natural overflow gives the wrap to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/csr_timer.sv
// csr_timer: TCFG/TVAL/TICLR/TID timer CSRs plus rdcnt read mux; stable counter when CSR_TIMER_STABLE_CNT_EN is defined.
// Latency: CSR writes visible one cycle later; rdcnt_data is combinational.
// Backpressure: stall drops (never defers) CSR writes; countdown and counter ignore stall.
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter int TVAL_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic        clk,
    input  logic        reset,
    csr_timer_if.slave  bus
);

    tcfg_t             tcfg;
    tcfg_t             wcfg;
    logic [TVAL_W-1:0] tval;
    logic [31:0]       tid;
    logic              timer_en;
    logic              timer_int;

    logic              tcfg_wr;
    logic              ticlr_wr;
    logic              tid_wr;
    logic              expire;
    logic              clr_int;
    logic [TVAL_W-1:0] reload_cur;
    logic [TVAL_W-1:0] reload_new;

    logic [CNT_W-1:0]  count;
    logic [63:0]       count_ext;
    logic [30:0]       unused_ticlr;

    assign tcfg_wr    = bus.tcfg_we  & ~bus.stall;
    assign ticlr_wr   = bus.ticlr_we & ~bus.stall;
    assign tid_wr     = bus.tid_we   & ~bus.stall;
    assign wcfg       = tcfg_t'(bus.tcfg_wdata);
    assign expire     = timer_en & (tval == '0);
    assign clr_int    = ticlr_wr & bus.ticlr_wdata[TICLR_CLR_BIT];
    assign reload_cur = TVAL_W'(tcfg_reload(tcfg));
    assign reload_new = TVAL_W'(tcfg_reload(wcfg));

    // Only the CLR bit of TICLR carries meaning
    assign unused_ticlr = bus.ticlr_wdata[31:1];

    // Countdown: a TCFG write always wins over the expiry reload/stop
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg     <= '0;
            tval     <= '0;
            timer_en <= 1'b0;
        end else if (tcfg_wr) begin
            tcfg     <= wcfg;
            tval     <= reload_new;
            timer_en <= wcfg.en;
        end else if (timer_en) begin
            if (tval != '0) begin
                tval <= tval - TVAL_W'(1);
            end else if (tcfg.periodic) begin
                tval <= reload_cur;
            end else begin
                tval     <= '1;
                timer_en <= 1'b0;
            end
        end
    end

    // Sticky interrupt: a fresh expiry beats a same-cycle clear so no event is lost
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_int <= 1'b0;
        end else if (expire) begin
            timer_int <= 1'b1;
        end else if (clr_int) begin
            timer_int <= 1'b0;
        end
    end

    // Timer ID register
    always_ff @(posedge clk) begin
        if (reset) begin
            tid <= '0;
        end else if (tid_wr) begin
            tid <= bus.tid_wdata;
        end
    end

`ifdef CSR_TIMER_STABLE_CNT_EN
    stable_counter #(
        .CNT_W (CNT_W)
    ) u_stable_cnt (
        .clk   (clk),
        .reset (reset),
        .count (count)
    );
`else
    assign count = '0;
`endif

    assign count_ext = 64'(count);

    // rdcnt read mux: OR of every selected source, zero when nothing is selected
    always_comb begin
        bus.rdcnt_data = '0;
        if (bus.rdcnt_op[RDCNT_VL_BIT]) bus.rdcnt_data = bus.rdcnt_data | count_ext[31:0];
        if (bus.rdcnt_op[RDCNT_VH_BIT]) bus.rdcnt_data = bus.rdcnt_data | count_ext[63:32];
        if (bus.rdcnt_op[RDCNT_ID_BIT]) bus.rdcnt_data = bus.rdcnt_data | tid;
    end

    assign bus.tcfg_out  = tcfg;
    assign bus.tval_out  = 32'(tval);
    assign bus.tid_out   = tid;
    assign bus.timer_int = timer_int;

endmodule
